// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result handshake bundle for the sequential divider.
// The divider connects through the slave modport; operand producers and
// result consumers connect through the master modport.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quot;
  logic [WIDTH-1:0] out_rem;
  logic             out_div_zero;

  modport slave (
    input  in_valid, in_dividend, in_divisor, in_signed, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_div_zero
  );

  modport master (
    output in_valid, in_dividend, in_divisor, in_signed, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_div_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per cycle.
// Works on magnitudes and applies signs on the last iteration so results
// match SystemVerilog '/' and '%' (truncation toward zero, min/-1 wraps).
// Optional feature macro: SEQ_DIVIDER_EARLY_OUT_EN -- when defined, operands
// with |dividend| < |divisor| skip the iteration loop and finish in one cycle.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);

  localparam int CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               quotNeg_q, quotNeg_d;
  logic               remNeg_q, remNeg_d;
  logic [WIDTH-1:0]   outQuot_q, outQuot_d;
  logic [WIDTH-1:0]   outRem_q, outRem_d;
  logic               outDivZero_q, outDivZero_d;

  logic [WIDTH-1:0]   dvdMag;
  logic [WIDTH-1:0]   dvsMag;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   nextRem;
  logic [WIDTH-1:0]   nextQuot;

  assign bus.in_ready     = (state_q == IDLE) && !rst;
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_quot     = outQuot_q;
  assign bus.out_rem      = outRem_q;
  assign bus.out_div_zero = outDivZero_q;

  // Next-state and datapath: accept operands, iterate one bit per cycle, hold result.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    rem_d        = rem_q;
    quotNeg_d    = quotNeg_q;
    remNeg_d     = remNeg_q;
    outQuot_d    = outQuot_q;
    outRem_d     = outRem_q;
    outDivZero_d = outDivZero_q;

    dvdMag = (bus.in_signed && bus.in_dividend[WIDTH-1]) ? -bus.in_dividend : bus.in_dividend;
    dvsMag = (bus.in_signed && bus.in_divisor[WIDTH-1])  ? -bus.in_divisor  : bus.in_divisor;

    // The partial remainder needs one extra bit: it can reach 2*|divisor|-1
    // before the trial subtraction, and |min| = 2^(WIDTH-1) must not overflow.
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, dvs_q});
    nextRem  = WIDTH'(ge ? (shifted - {1'b0, dvs_q}) : shifted);
    nextQuot = {dvd_q[WIDTH-2:0], ge};

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_divisor == '0) begin
            outQuot_d    = '1;
            outRem_d     = bus.in_dividend;
            outDivZero_d = 1'b1;
            state_d      = DONE;
          end
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
          else if (dvdMag < dvsMag) begin
            outQuot_d    = '0;
            outRem_d     = bus.in_dividend;
            outDivZero_d = 1'b0;
            state_d      = DONE;
          end
`endif
          else begin
            dvd_d     = dvdMag;
            dvs_d     = dvsMag;
            rem_d     = '0;
            cnt_d     = CntW'(WIDTH);
            quotNeg_d = bus.in_signed && (bus.in_dividend[WIDTH-1] ^ bus.in_divisor[WIDTH-1]);
            remNeg_d  = bus.in_signed && bus.in_dividend[WIDTH-1];
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        rem_d = nextRem;
        dvd_d = nextQuot;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          outQuot_d    = quotNeg_q ? -nextQuot : nextQuot;
          outRem_d     = remNeg_q  ? -nextRem  : nextRem;
          outDivZero_d = 1'b0;
          state_d      = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      quotNeg_q    <= 1'b0;
      remNeg_q     <= 1'b0;
      outQuot_q    <= '0;
      outRem_q     <= '0;
      outDivZero_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      rem_q        <= rem_d;
      quotNeg_q    <= quotNeg_d;
      remNeg_q     <= remNeg_d;
      outQuot_q    <= outQuot_d;
      outRem_q     <= outRem_d;
      outDivZero_q <= outDivZero_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of seq_divider at WIDTH=8 covering reset,
// unsigned/signed results, divide-by-zero, backpressure, mid-operation reset
// and the small-dividend case (latency depends on SEQ_DIVIDER_EARLY_OUT_EN).
module tb_seq_divider;

  localparam int W = 8;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  localparam int EarlyLat = 1;
`else
  localparam int EarlyLat = 9;
`endif

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case a wait loop is ever broken.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for in_ready, present one request for exactly one accepting edge,
  // then scramble the inputs to show they are no longer sampled.
  task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_dividend = dvd;
    bus.in_divisor  = dvs;
    bus.in_signed   = sgn;
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.in_dividend = 8'h55;
    bus.in_divisor  = 8'h01;
    bus.in_signed   = ~sgn;
  endtask

  // Count edges (including the accept edge) until out_valid, noting whether
  // in_ready ever rose meanwhile.
  task automatic waitValid(output int lat, output logic readyLow);
    lat = 1;
    readyLow = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) readyLow = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.in_ready) readyLow = 1'b0;
  endtask

  // One complete operation with out_ready held high.
  task automatic runOp(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ed, input int elat);
    int   lat;
    logic readyLow;
    applyStimulus(dvd, dvs, sgn);
    waitValid(lat, readyLow);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(elat));
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_readylow"}, 32'(readyLow), 32'd1);
    checkOutput({tag, "_quot"}, 32'(bus.out_quot), 32'(eq));
    checkOutput({tag, "_rem"}, 32'(bus.out_rem), 32'(er));
    checkOutput({tag, "_dz"}, 32'(bus.out_div_zero), 32'(ed));
    @(posedge clk);
    #1;
    checkOutput({tag, "_validdrop"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_readyback"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Directed sequence of all scenarios.
  initial begin
    int   lat;
    logic readyLow;
    logic sawValid;

    compared        = 0;
    mismatched      = 0;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.in_signed   = 1'b0;
    bus.out_ready   = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_quot", 32'(bus.out_quot), 32'd0);
    checkOutput("rst_rem", 32'(bus.out_rem), 32'd0);
    checkOutput("rst_dz", 32'(bus.out_div_zero), 32'd0);
    checkOutput("rst_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_ready", 32'(bus.in_ready), 32'd1);

    $display("[TB] basic unsigned and signed division");
    runOp("u100_7",   8'd100, 8'd7,   1'b0, 8'd14,  8'd2,  1'b0, 9);
    runOp("u255_16",  8'd255, 8'd16,  1'b0, 8'd15,  8'd15, 1'b0, 9);
    runOp("sm7_2",    8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF, 1'b0, 9);
    runOp("s7_m2",    8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01, 1'b0, 9);
    runOp("smin_m1",  8'h80,  8'hFF,  1'b1, 8'h80,  8'h00, 1'b0, 9);
    runOp("sm100_7",  8'h9C,  8'h07,  1'b1, 8'hF2,  8'hFE, 1'b0, 9);
    runOp("uF9_2",    8'hF9,  8'h02,  1'b0, 8'h7C,  8'h01, 1'b0, 9);

    $display("[TB] divide by zero");
    runOp("u_dz",     8'h2A,  8'h00,  1'b0, 8'hFF,  8'h2A, 1'b1, 1);
    runOp("s_dz",     8'h2A,  8'h00,  1'b1, 8'hFF,  8'h2A, 1'b1, 1);
    runOp("after_dz", 8'd20,  8'd6,   1'b0, 8'd3,   8'd2,  1'b0, 9);

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(8'd200, 8'd3, 1'b0);
    waitValid(lat, readyLow);
    checkOutput("bp_lat", 32'(lat), 32'd9);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_dividend = 8'd10;
    bus.in_divisor  = 8'd2;
    bus.in_signed   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_hold_quot", 32'(bus.out_quot), 32'd66);
      checkOutput("bp_hold_rem", 32'(bus.out_rem), 32'd2);
      checkOutput("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("bp_not_queued", 32'(bus.in_ready), 32'd1);

    $display("[TB] reset during iteration");
    applyStimulus(8'd250, 8'd5, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("midrst_quot", 32'(bus.out_quot), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_release_ready", 32'(bus.in_ready), 32'd1);
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("midrst_no_result", 32'(sawValid), 32'd0);
    runOp("u9_4",     8'd9,   8'd4,   1'b0, 8'd2,   8'd1,  1'b0, 9);

    $display("[TB] small dividend");
    runOp("u3_10",    8'd3,   8'd10,  1'b0, 8'd0,   8'd3,  1'b0, EarlyLat);
    runOp("sm3_10",   8'hFD,  8'd10,  1'b1, 8'd0,   8'hFD, 1'b0, EarlyLat);
    runOp("u5_5",     8'd5,   8'd5,   1'b0, 8'd1,   8'd0,  1'b0, 9);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
